// File: rtl/cnn_conv_engine.sv
// KxK valid 2-D convolution engine over a single-port memory handshake.
// Taps are loaded once per job; each output is a KxK fetch pass followed by one write.
module cnn_conv_engine #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 12,
  parameter int K         = 3,
  parameter int DIM_W     = 6,
  parameter int FRAC_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              relu_en,
  input  logic [ADDR_W-1:0] img_base,
  input  logic [ADDR_W-1:0] ker_base,
  input  logic [ADDR_W-1:0] out_base,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] from_memory,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] to_memory,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        state_o
);

  localparam int KK    = K * K;
  localparam int CW    = (KK > 1) ? $clog2(KK) : 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  localparam int ACC_W = 2 * DATA_W + $clog2(KK);
  localparam int LW    = 2 * DIM_W + 2;

  localparam logic [DIM_W-1:0] K_DIM = DIM_W'(K);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_K = 3'd1,
    FETCH  = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic                     relu_q;
  logic                     err_q;
  logic [ADDR_W-1:0]        img_base_q, ker_base_q, out_base_q;
  logic [DIM_W-1:0]         img_w_q, out_w_q, oy_last_q;
  logic [CW-1:0]            cnt_q;
  logic [KW-1:0]            kx_q, ky_q;
  logic [DIM_W-1:0]         ox_q, oy_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [DATA_W-1:0] tap_q [KK];

  logic                     dims_bad;
  logic                     last_tap, kx_last, ox_last, oy_last;
  logic [LW-1:0]            img_lin, out_lin;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_shift;
  logic [DATA_W-1:0]        wr_data;

  assign dims_bad = (img_w < K_DIM) || (img_h < K_DIM);
  assign last_tap = (cnt_q == CW'(KK - 1));
  assign kx_last  = (kx_q == KW'(K - 1));
  assign ox_last  = (ox_q == out_w_q - DIM_W'(1));
  assign oy_last  = (oy_q == oy_last_q);

  // Linear offsets are computed wide, then wrapped to the address width.
  assign img_lin = (LW'(oy_q) + LW'(ky_q)) * LW'(img_w_q) + LW'(ox_q) + LW'(kx_q);
  assign out_lin = LW'(oy_q) * LW'(out_w_q) + LW'(ox_q);

  // cnt_q doubles as the tap index (ky*K+kx) during FETCH.
  assign prod      = $signed(from_memory) * tap_q[cnt_q];
  assign prod_ext  = ACC_W'(prod);
  assign acc_shift = acc_q >>> FRAC_BITS;

  always_comb begin
    wr_data = acc_shift[DATA_W-1:0];
    if (acc_shift > SAT_MAX) begin
      wr_data = SAT_MAX[DATA_W-1:0];
    end else if (acc_shift < SAT_MIN) begin
      wr_data = SAT_MIN[DATA_W-1:0];
    end
    if (relu_q && acc_shift[ACC_W-1]) begin
      wr_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    address   = '0;
    to_memory = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = dims_bad ? DONE : LOAD_K;
        end
      end
      LOAD_K: begin
        mem_rd_en = 1'b1;
        address   = ker_base_q + ADDR_W'(cnt_q);
        if (mem_ready && last_tap) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        mem_rd_en = 1'b1;
        address   = img_base_q + ADDR_W'(img_lin);
        if (mem_ready && last_tap) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        mem_wr_en = 1'b1;
        address   = out_base_q + ADDR_W'(out_lin);
        to_memory = wr_data;
        if (mem_ready) begin
          state_d = (ox_last && oy_last) ? DONE : FETCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      relu_q     <= 1'b0;
      err_q      <= 1'b0;
      img_base_q <= '0;
      ker_base_q <= '0;
      out_base_q <= '0;
      img_w_q    <= '0;
      out_w_q    <= '0;
      oy_last_q  <= '0;
      cnt_q      <= '0;
      kx_q       <= '0;
      ky_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      acc_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            relu_q     <= relu_en;
            err_q      <= dims_bad;
            img_base_q <= img_base;
            ker_base_q <= ker_base;
            out_base_q <= out_base;
            img_w_q    <= img_w;
            out_w_q    <= img_w - K_DIM + DIM_W'(1);
            oy_last_q  <= img_h - K_DIM;
            cnt_q      <= '0;
            kx_q       <= '0;
            ky_q       <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            acc_q      <= '0;
          end
        end
        LOAD_K: begin
          if (mem_ready) begin
            cnt_q <= last_tap ? '0 : cnt_q + CW'(1);
          end
        end
        FETCH: begin
          if (mem_ready) begin
            acc_q <= acc_q + prod_ext;
            if (last_tap) begin
              cnt_q <= '0;
              kx_q  <= '0;
              ky_q  <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
              if (kx_last) begin
                kx_q <= '0;
                ky_q <= ky_q + KW'(1);
              end else begin
                kx_q <= kx_q + KW'(1);
              end
            end
          end
        end
        WRITE: begin
          if (mem_ready) begin
            acc_q <= '0;
            if (ox_last) begin
              ox_q <= '0;
              oy_q <= oy_q + DIM_W'(1);
            end else begin
              ox_q <= ox_q + DIM_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Tap registers only load during LOAD_K, so they need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < KK; i++) begin
      if (state_q == LOAD_K && mem_ready && cnt_q == CW'(i)) begin
        tap_q[i] <= $signed(from_memory);
      end
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign err     = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_cnn_conv_engine.sv
// Directed bench for cnn_conv_engine: 4x4 image jobs against a behavioural memory.
module tb_cnn_conv_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        relu_en;
  logic [11:0] img_base, ker_base, out_base;
  logic [5:0]  img_w, img_h;
  logic        mem_ready = 1'b1;
  logic [15:0] from_memory;
  logic        mem_rd_en, mem_wr_en;
  logic [11:0] address;
  logic [15:0] to_memory;
  logic        busy, done, err;
  logic [2:0]  state_o;

  cnn_conv_engine #(
    .DATA_W(16), .ADDR_W(12), .K(3), .DIM_W(6), .FRAC_BITS(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
    .img_base(img_base), .ker_base(ker_base), .out_base(out_base),
    .img_w(img_w), .img_h(img_h), .mem_ready(mem_ready),
    .from_memory(from_memory), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .address(address), .to_memory(to_memory), .busy(busy), .done(done),
    .err(err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Input memory (image/kernel) is preloaded by the stimulus; results land in omem.
  logic [15:0] mem  [4096];
  logic [15:0] omem [4096];
  assign from_memory = mem[address];

  logic rand_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    mem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  int checks = 0;
  int failures = 0;
  int n_req = 0, n_wr = 0, viol = 0, n_oob = 0;
  logic        pend = 1'b0;
  logic        p_wr;
  logic [11:0] p_addr;
  logic [15:0] p_data;

  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (mem_rd_en && mem_wr_en) viol++;
      if (pend) begin
        if ((p_wr ? !mem_wr_en : !mem_rd_en) || address != p_addr ||
            (p_wr && to_memory != p_data)) viol++;
      end
      if (mem_rd_en || mem_wr_en) n_req++;
      if (mem_wr_en && mem_ready) begin
        omem[address] = to_memory;
        n_wr++;
        if (address < 12'h300 || address > 12'h303) n_oob++;
      end
      pend   = (mem_rd_en || mem_wr_en) && !mem_ready;
      p_wr   = mem_wr_en;
      p_addr = address;
      p_data = to_memory;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] e0, e1, e2, e3);
    chk({tag, "_o0"}, 32'(omem[12'h300]), 32'(e0));
    chk({tag, "_o1"}, 32'(omem[12'h301]), 32'(e1));
    chk({tag, "_o2"}, 32'(omem[12'h302]), 32'(e2));
    chk({tag, "_o3"}, 32'(omem[12'h303]), 32'(e3));
  endtask

  task automatic load_img(input logic [15:0] fixed_val, input bit ramp);
    for (int i = 0; i < 16; i++) mem[12'h100 + 12'(i)] = ramp ? 16'(i + 1) : fixed_val;
  endtask

  task automatic load_ker(input logic [15:0] val, input bit centre_only);
    for (int i = 0; i < 9; i++) mem[12'h200 + 12'(i)] = (!centre_only || i == 4) ? val : 16'h0000;
  endtask

  // Launch a job with start for one cycle; lat = cycle index at which done is seen.
  task automatic run_job(input logic [5:0] w, h, input bit relu, input bit poke, output int lat);
    @(posedge clk); #1;
    img_base = 12'h100; ker_base = 12'h200; out_base = 12'h300;
    img_w = w; img_h = h; relu_en = relu; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20000) begin
      @(posedge clk); #1;
      lat++;
      start = poke && (lat == 5);
      if (start) out_base = 12'h380;
    end
    start = 1'b0;
    chk("timeout", 32'(lat < 20000), 32'd1);
    @(posedge clk); #1;
    chk("done_pulse", {29'd0, done, state_o == 3'd0, busy}, 32'h2);
    $display("job w=%0d h=%0d relu=%0d poke=%0d latency=%0d err=%0d", w, h, relu, poke, lat, err);
  endtask

  int lat, w0, w1, r0, cnt;

  initial begin
    rst = 1'b1; start = 1'b0; relu_en = 1'b0;
    img_base = '0; ker_base = '0; out_base = '0; img_w = '0; img_h = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_ctrl", {27'd0, mem_rd_en, mem_wr_en, busy, done, err}, 32'd0);
    chk("rst_bus", {4'd0, address, to_memory}, 32'd0);
    rst = 1'b0;

    load_img(16'h0, 1'b1);
    load_ker(16'h0100, 1'b1);
    run_job(6'd4, 6'd4, 1'b0, 1'b0, lat);
    chk("ident_lat", 32'(lat), 32'd50);
    chk("ident_err", 32'(err), 32'd0);
    chk_out("ident", 16'd6, 16'd7, 16'd10, 16'd11);

    load_ker(16'h0100, 1'b0);
    run_job(6'd4, 6'd4, 1'b0, 1'b0, lat);
    chk("ones_lat", 32'(lat), 32'd50);
    chk_out("ones", 16'd54, 16'd63, 16'd90, 16'd99);

    load_img(16'h7FFF, 1'b0);
    load_ker(16'h7FFF, 1'b0);
    run_job(6'd4, 6'd4, 1'b0, 1'b0, lat);
    chk_out("satp", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    load_ker(16'h8001, 1'b0);
    run_job(6'd4, 6'd4, 1'b0, 1'b0, lat);
    chk_out("satn", 16'h8000, 16'h8000, 16'h8000, 16'h8000);
    run_job(6'd4, 6'd4, 1'b1, 1'b0, lat);
    chk_out("relu", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    load_img(16'h0, 1'b1);
    load_ker(16'h0100, 1'b0);
    rand_ready = 1'b1;
    run_job(6'd4, 6'd4, 1'b0, 1'b0, lat);
    rand_ready = 1'b0;
    chk("bp_slower", 32'(lat > 50), 32'd1);
    chk_out("bp", 16'd54, 16'd63, 16'd90, 16'd99);
    chk("bp_protocol", 32'(viol), 32'd0);

    r0 = n_req;
    run_job(6'd2, 6'd4, 1'b0, 1'b0, lat);
    chk("bad_lat", 32'(lat), 32'd1);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_noreq", 32'(n_req - r0), 32'd0);
    load_ker(16'h0100, 1'b1);
    run_job(6'd4, 6'd4, 1'b0, 1'b0, lat);
    chk("clr_err", 32'(err), 32'd0);
    chk_out("clr", 16'd6, 16'd7, 16'd10, 16'd11);

    // Abort in the middle of the second output's fetch pass.
    load_ker(16'h0100, 1'b0);
    @(posedge clk); #1;
    img_w = 6'd4; img_h = 6'd4; relu_en = 1'b0; out_base = 12'h300; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w0 = n_wr;
    cnt = 0;
    while (!(n_wr == w0 + 1 && state_o == 3'd2) && cnt < 2000) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("rst_reach", 32'(cnt < 2000), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_state", 32'(state_o), 32'd0);
    chk("abort_ctrl", {27'd0, mem_rd_en, mem_wr_en, busy, done, err}, 32'd0);
    chk("abort_bus", {4'd0, address, to_memory}, 32'd0);
    rst = 1'b0;
    w1 = n_wr;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_nowr", 32'(n_wr - w1), 32'd0);
    chk("abort_first", 32'(omem[12'h300]), 32'd54);
    $display("job aborted by reset writes_before=%0d", w1 - w0);

    load_ker(16'h0100, 1'b1);
    w0 = n_wr;
    run_job(6'd4, 6'd4, 1'b0, 1'b1, lat);
    chk("poke_lat", 32'(lat), 32'd50);
    chk("poke_nwr", 32'(n_wr - w0), 32'd4);
    chk_out("poke", 16'd6, 16'd7, 16'd10, 16'd11);
    repeat (10) @(posedge clk);
    #1;
    chk("poke_idle", {28'd0, busy, state_o}, 32'd0);
    chk("oob_writes", 32'(n_oob), 32'd0);
    chk("protocol", 32'(viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
